// File: rtl/video_mode_pkg.sv
// Shared definitions for the video mode controller: FSM encoding, default
// thresholds and small arithmetic helpers used by the datapath.
package video_mode_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2
    } vm_state_t;

    localparam int unsigned DEF_TOL          = 4;
    localparam int unsigned DEF_LOCK_LINES   = 16;
    localparam int unsigned DEF_UNLOCK_LINES = 8;
    localparam int unsigned DEF_HS31_MAX     = 1200;
    localparam int unsigned DEF_CE_SPLIT     = 1800;

    localparam int unsigned PERIOD_W = 12;
    localparam int unsigned LINES_W  = 10;
    localparam int unsigned CNT_W    = 16;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    // True when two line periods differ by no more than tol cycles.
    function automatic logic within_tol(input logic [PERIOD_W-1:0] a,
                                        input logic [PERIOD_W-1:0] b,
                                        input int unsigned tol);
        logic [PERIOD_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {20'd0, d} <= tol;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/video_mode_ctrl_sync_period_meter.sv
// Sync input conditioning and timing measurement: two-flop synchronizers,
// falling-edge detection, saturating line-period and lines-per-frame counters.
module sync_period_meter
    import video_mode_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                HSync,
    input  logic                VSync,
    output logic                hs_event,
    output logic                vs_event,
    output logic                timeout,
    output logic [PERIOD_W-1:0] line_period,
    output logic [PERIOD_W-1:0] h_period,
    output logic [LINES_W-1:0]  v_lines
);

    // [1:0] synchronize, [2] holds the previous synchronized level.
    logic [2:0]          hs_sr;
    logic [2:0]          vs_sr;
    logic [PERIOD_W-1:0] period_cnt;
    logic [LINES_W-1:0]  line_cnt;
    logic [LINES_W-1:0]  line_cnt_inc;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_sr <= '1;
            vs_sr <= '1;
        end else begin
            hs_sr <= {hs_sr[1:0], HSync};
            vs_sr <= {vs_sr[1:0], VSync};
        end
    end

    assign hs_event     = hs_sr[2] & ~hs_sr[1];
    assign vs_event     = vs_sr[2] & ~vs_sr[1];
    assign timeout      = ~hs_event && (period_cnt == PERIOD_MAX - PERIOD_W'(1));
    assign line_period  = period_cnt;
    assign line_cnt_inc = (line_cnt == '1) ? line_cnt : line_cnt + LINES_W'(1);

    // Reaching saturation also publishes 4095 so a lost sync is visible on h_period.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
            h_period   <= '0;
        end else if (hs_event) begin
            h_period   <= period_cnt;
            period_cnt <= PERIOD_W'(1);
        end else if (period_cnt != PERIOD_MAX) begin
            period_cnt <= period_cnt + PERIOD_W'(1);
            if (timeout) begin
                h_period <= PERIOD_MAX;
            end
        end
    end

    // A line ending on the same cycle as VSync belongs to the closing frame.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt <= '0;
            v_lines  <= '0;
        end else if (vs_event) begin
            v_lines  <= hs_event ? line_cnt_inc : line_cnt;
            line_cnt <= '0;
        end else if (hs_event) begin
            line_cnt <= line_cnt_inc;
        end
    end

endmodule

// File: rtl/video_mode_ctrl.sv
// Video mode detector: locks onto a stable line period and derives the
// scandoubler bypass and pixel clock-enable configuration from it.
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter int unsigned TOL          = DEF_TOL,
    parameter int unsigned LOCK_LINES   = DEF_LOCK_LINES,
    parameter int unsigned UNLOCK_LINES = DEF_UNLOCK_LINES,
    parameter int unsigned HS31_MAX     = DEF_HS31_MAX,
    parameter int unsigned CE_SPLIT     = DEF_CE_SPLIT
)(
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                HSync,
    input  logic                VSync,
    input  logic                user_sd_off,
    output logic                scandoubler_disable,
    output logic                ce_divider,
    output logic                locked,
    output logic [PERIOD_W-1:0] h_period,
    output logic [LINES_W-1:0]  v_lines,
    output logic                mode_change
);

    vm_state_t           state;
    vm_state_t           state_next;
    logic                hs_event;
    logic                vs_event;
    logic                timeout;
    logic [PERIOD_W-1:0] line_period;
    logic [PERIOD_W-1:0] ref_period;
    logic [PERIOD_W-1:0] ref_next;
    logic [CNT_W-1:0]    match_cnt;
    logic [CNT_W-1:0]    match_next;
    logic [CNT_W-1:0]    miss_cnt;
    logic [CNT_W-1:0]    miss_next;
    logic                line_match;
    logic                enter_lock;
    logic                ce_div_new;
    logic                sd31_new;
    logic                ce_div_l;
    logic                sd31_l;
    logic                latched_once;

    sync_period_meter u_meter (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .HSync       (HSync),
        .VSync       (VSync),
        .hs_event    (hs_event),
        .vs_event    (vs_event),
        .timeout     (timeout),
        .line_period (line_period),
        .h_period    (h_period),
        .v_lines     (v_lines)
    );

    assign line_match = within_tol(line_period, ref_period, TOL);

    // Line bookkeeping is resolved before the frame decision so a line and a
    // VSync arriving together are judged with that line already counted.
    always_comb begin
        ref_next   = ref_period;
        match_next = match_cnt;
        miss_next  = miss_cnt;
        if (timeout) begin
            match_next = '0;
            miss_next  = '0;
        end else if (hs_event) begin
            case (state)
                UNLOCKED: begin
                    ref_next   = line_period;
                    match_next = '0;
                    miss_next  = '0;
                end
                MEASURE: begin
                    if (line_match) begin
                        match_next = sat_inc(match_cnt);
                    end else begin
                        ref_next   = line_period;
                        match_next = '0;
                    end
                end
                LOCKED: miss_next = line_match ? '0 : sat_inc(miss_cnt);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ref_period <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else begin
            ref_period <= ref_next;
            match_cnt  <= match_next;
            miss_cnt   <= miss_next;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = UNLOCKED;
        end else begin
            case (state)
                UNLOCKED: if (hs_event) state_next = MEASURE;
                MEASURE:  if (vs_event && 32'(match_next) >= LOCK_LINES) state_next = LOCKED;
                LOCKED:   if (32'(miss_next) >= UNLOCK_LINES) state_next = UNLOCKED;
                default:  state_next = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        locked     = (state == LOCKED);
        enter_lock = (state != LOCKED) && (state_next == LOCKED);
        ce_div_new = 32'(ref_next) < CE_SPLIT;
        sd31_new   = 32'(ref_next) < HS31_MAX;
    end

    // The first lock after reset always announces itself, since nothing was latched before.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce_div_l            <= 1'b0;
            sd31_l              <= 1'b0;
            latched_once        <= 1'b0;
            mode_change         <= 1'b0;
            scandoubler_disable <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            if (enter_lock) begin
                ce_div_l     <= ce_div_new;
                sd31_l       <= sd31_new;
                latched_once <= 1'b1;
                mode_change  <= !latched_once || (ce_div_new != ce_div_l) || (sd31_new != sd31_l);
            end
            scandoubler_disable <= user_sd_off | sd31_l;
        end
    end

    assign ce_divider = ce_div_l;

endmodule

// File: doc/video_mode_ctrl.md
VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 SHALL have parameter TOL, default 4: max |line period - reference| in clk_sys cycles counted as a match.
REQ-002 SHALL have parameter LOCK_LINES, default 16: consecutive matching lines required to lock.
REQ-003 SHALL have parameter UNLOCK_LINES, default 8: consecutive mismatching lines that drop lock.
REQ-004 SHALL have parameter HS31_MAX, default 1200: periods below this value are 31 kHz input.
REQ-005 SHALL have parameter CE_SPLIT, default 1800: periods at or above this value select the clk_sys/4 pixel enable.
REQ-006 SHALL have port clk_sys, input, 1: the only clock.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port HSync, input, 1: core horizontal sync, active-low.
REQ-009 SHALL have port VSync, input, 1: core vertical sync, active-low.
REQ-010 SHALL have port user_sd_off, input, 1: OSD request to bypass the scandoubler.
REQ-011 SHALL have port scandoubler_disable, output, 1: configuration for the video pipeline.
REQ-012 SHALL have port ce_divider, output, 1: 0 = clk_sys/4, 1 = clk_sys/2.
REQ-013 SHALL have port locked, output, 1: stable mode detected.
REQ-014 SHALL have port h_period, output, 12: last measured line period, in cycles.
REQ-015 SHALL have port v_lines, output, 10: lines in the last complete frame.
REQ-016 SHALL have port mode_change, output, 1: one-cycle pulse when the latched configuration changes.

Function
REQ-017 SHALL pass HSync and VSync through two-flop synchronizers; each event is the falling edge of the synchronized signal.
REQ-018 SHALL count cycles between consecutive HSync events in a 12-bit counter that saturates at 4095 and never wraps.
REQ-019 SHALL load h_period with the counter value on each HSync event; the counter restarts at 1 on the same cycle.
REQ-020 SHALL count HSync events per frame, saturating at 1023, and load v_lines on each VSync event.
REQ-021 SHALL implement FSM states UNLOCKED, MEASURE, LOCKED.
REQ-022 UNLOCKED: on an HSync event, capture the period as the reference, clear the match count and enter MEASURE.
REQ-023 MEASURE: a matching line increments the match count; a mismatching line replaces the reference and clears the count.
REQ-024 MEASURE -> LOCKED SHALL occur on the first VSync event after match count >= LOCK_LINES.
REQ-025 LOCKED: each mismatching line increments the mismatch count and each matching line clears it; reaching UNLOCK_LINES -> UNLOCKED.
REQ-026 Saturation of the period counter at 4095 (sync timeout) SHALL force UNLOCKED from any state.
REQ-027 On entry to LOCKED, the block SHALL latch ce_div_l = (reference < CE_SPLIT) and sd31_l = (reference < HS31_MAX).
REQ-028 mode_change SHALL pulse for exactly one cycle when ce_div_l or sd31_l differs from its previously latched value.
REQ-029 Latched values SHALL hold through UNLOCKED and MEASURE; the outputs never glitch during relock.
REQ-030 scandoubler_disable SHALL equal user_sd_off OR sd31_l, registered, so it changes 1 cycle after either input changes.
REQ-031 ce_divider SHALL equal ce_div_l; locked SHALL be 1 only in LOCKED.
REQ-032 When HSync and VSync events occur in the same cycle, the HSync event SHALL be processed first, so that line is counted in the closing frame.

Reset
REQ-033 Reset SHALL force: state UNLOCKED; locked 0; mode_change 0; scandoubler_disable 0; ce_divider 0; h_period 0; v_lines 0; all counters 0.
REQ-034 reset_n asserted mid-frame SHALL take effect immediately; measurement restarts from the first HSync event after release.

Structure
REQ-035 A shared package video_mode_pkg SHALL hold the FSM state encoding and the default TOL, LOCK_LINES, UNLOCK_LINES, HS31_MAX and CE_SPLIT values.
REQ-036 A single sub-module, sync_period_meter, SHALL implement REQ-017 to REQ-020 (synchronizers, edge detection, saturating counters) and is instantiated once.

Verification
REQ-037 The bench SHALL cover: 20 lines at period 2048, VSync after line 20 -> locked=1, ce_divider=0, scandoubler_disable=0, mode_change pulses once.
REQ-038 The bench SHALL cover: locked at 2048, then period 1000 for 8 lines -> locked=0 after the 8th line; outputs hold; relock at 1000 -> ce_divider=1, scandoubler_disable=1.
REQ-039 The bench SHALL cover: locked at 2048 with jitter of +/-4 cycles -> locked stays 1; jitter of +/-5 on 7 consecutive lines then one clean line -> still locked.
REQ-040 The bench SHALL cover: HSync stopped for 5000 cycles -> h_period=4095 and locked=0 at saturation.
REQ-041 The bench SHALL cover: user_sd_off toggled while locked at 2048 -> scandoubler_disable follows 1 cycle later; mode_change is not asserted.
REQ-042 The bench SHALL cover: 262 lines per frame -> v_lines=262; reset_n pulsed mid-frame -> all outputs read their reset values.
